// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: PC, single-outstanding
// imem requests, one-entry skid buffer for ID stalls and branch redirect/flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_stall,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_npc;
  logic [31:0] pc_next;
  logic [31:0] redirect_pc;
  logic        out_free;

  assign pc_next     = pc + 32'd4;
  assign redirect_pc = {br_target[31:2], 2'b00};
  assign out_free    = !out_valid || !id_stall;

  // The request is a pure decode of the state register, gated so it stays low
  // for the whole time reset is asserted rather than only after the next edge.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;

  // NOTE: every register here is updated with <= so all branches of the FSM
  // see the pre-edge values of pc/state/outputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_npc   <= 32'd0;
      instr_out  <= NOP_INSTR;
      npc_out    <= 32'd0;
      out_valid  <= 1'b0;
    end else if (br_taken) begin
      // Flush overrides any stall; the skid is emptied simply by leaving HOLD.
      pc        <= redirect_pc;
      out_valid <= 1'b0;
      instr_out <= NOP_INSTR;
      unique case (state)
        FETCH:   state <= imem_rvalid ? FETCH : DROP;
        HOLD:    state <= FETCH;
        DROP:    state <= imem_rvalid ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_rvalid) begin
            pc <= pc_next;
            if (out_free) begin
              instr_out <= imem_rdata;
              npc_out   <= pc_next;
              out_valid <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_npc   <= pc_next;
              state      <= HOLD;
            end
          end else if (out_valid && !id_stall) begin
            out_valid <= 1'b0;
            instr_out <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            instr_out <= skid_instr;
            npc_out   <= skid_npc;
            out_valid <= 1'b1;
            state     <= FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: the bench plays instruction memory by hand,
// answering each request one cycle later, and checks against hand-derived values.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_stall;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target), .id_stall(id_stall),
    .instr_out(instr_out), .npc_out(npc_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it, away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    br_taken = 1'b0; br_target = '0; id_stall = 1'b0;
    #12;
    check("rst_req", imem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", instr_out, NOP);
    check("rst_npc", npc_out, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("t1_req", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h0);

    // 1: first fetch answered one cycle after the request
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
    step();
    imem_rvalid = 1'b0;
    check("t1_instr", instr_out, 32'h8C01_0004);
    check("t1_npc", npc_out, 32'd4);
    check("t1_valid", out_valid, 1);
    check("t1_addr4", imem_addr, 32'd4);
    check("t1_req4", imem_req, 1);

    // 2: ID stalls three cycles; response for 4 lands in the skid
    id_stall = 1'b1;
    step();
    check("t2_hold_instr", instr_out, 32'h8C01_0004);
    imem_rvalid = 1'b1; imem_rdata = 32'h0042_0093;
    step();
    imem_rvalid = 1'b0;
    check("t2_req_off", imem_req, 0);
    check("t2_instr_held", instr_out, 32'h8C01_0004);
    check("t2_npc_held", npc_out, 32'd4);
    check("t2_valid_held", out_valid, 1);
    step();
    check("t2_req_off2", imem_req, 0);
    check("t2_instr_held2", instr_out, 32'h8C01_0004);
    id_stall = 1'b0;
    step();
    check("t2_instr4", instr_out, 32'h0042_0093);
    check("t2_npc8", npc_out, 32'd8);
    check("t2_valid", out_valid, 1);
    check("t2_req8", imem_req, 1);
    check("t2_addr8", imem_addr, 32'd8);

    // 3: redirect to 0x40 while the fetch of 8 is still outstanding
    br_taken = 1'b1; br_target = 32'h40;
    step();
    br_taken = 1'b0;
    check("t3_flush_valid", out_valid, 0);
    check("t3_flush_instr", instr_out, NOP);
    check("t3_drop_req", imem_req, 0);
    step();
    check("t3_drop_req2", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("t3_stale_valid", out_valid, 0);
    check("t3_stale_instr", instr_out, NOP);
    check("t3_req40", imem_req, 1);
    check("t3_addr40", imem_addr, 32'h40);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_0001;
    step();
    imem_rvalid = 1'b0;
    check("t3_instr40", instr_out, 32'h1111_0001);
    check("t3_npc44", npc_out, 32'h44);
    check("t3_valid", out_valid, 1);

    // bubble: consumed output with no new response
    step();
    check("bubble_valid", out_valid, 0);
    check("bubble_instr", instr_out, NOP);

    // 4: redirect coinciding with a response; target low bits ignored
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_0002;
    br_taken = 1'b1; br_target = 32'h43;
    step();
    imem_rvalid = 1'b0; br_taken = 1'b0;
    check("t4_req", imem_req, 1);
    check("t4_addr40", imem_addr, 32'h40);
    check("t4_valid", out_valid, 0);
    check("t4_instr", instr_out, NOP);

    // 6: PC wrap at the top of the address space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    step();
    br_taken = 1'b0;
    check("t6_drop_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("t6_valid_pre", out_valid, 0);
    imem_rdata = 32'h3333_3333;
    step();
    imem_rvalid = 1'b0;
    check("t6_instr", instr_out, 32'h3333_3333);
    check("t6_npc_wrap", npc_out, 32'h0);
    check("t6_addr_wrap", imem_addr, 32'h0);

    // 5: asynchronous reset in the middle of HOLD
    id_stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    step();
    imem_rvalid = 1'b0;
    check("t5_in_hold", imem_req, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_instr", instr_out, NOP);
    check("t5_rst_req", imem_req, 0);
    check("t5_rst_npc", npc_out, 0);
    id_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    check("t5_req_after", imem_req, 1);
    check("t5_addr_after", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
